// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the round-robin multiply-add arbiter:
//   - default operand / result widths
//   - FSM state encoding (IDLE, COMPUTE, RESP)
//   - id_width(): bits needed to hold a requester index
// Optional feature macro used elsewhere in this slice: MAC_ACCUM_EN
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int OUT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_e;

    // At least one bit, so a 2-requester build still has a usable ID field.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mac_rr_arbiter_if
// Request/response bundle between the operand sources and the shared MAC.
//   req_valid/req_ready : per-requester handshake (req_ready one-hot)
//   req_a/b/c           : flattened operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_acc             : per-requester accumulate select (only with MAC_ACCUM_EN)
//   rsp_valid/rsp_ready : single response channel with backpressure
//   rsp_data/rsp_id     : result and owning requester index
//   busy                : arbiter not in IDLE
// Modports: master = requester/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mac_rr_arbiter_if
    import mac_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) ();
    localparam int ID_WIDTH = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_c;
`ifdef MAC_ACCUM_EN
    logic [NUM_REQ-1:0]            req_acc;
`endif
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [OUT_WIDTH-1:0]          rsp_data;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic                          busy;

    modport master (
        output req_valid, req_a, req_b, req_c, rsp_ready,
`ifdef MAC_ACCUM_EN
        output req_acc,
`endif
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, rsp_ready,
`ifdef MAC_ACCUM_EN
        input  req_acc,
`endif
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/mac_rr_pick.sv
// ---------------------------------------------------------------------------
// mac_rr_pick
// Combinational round-robin picker, reusable for any shared resource.
//   req       : request vector
//   ptr       : highest-priority index this round
//   grant     : one-hot winner (all zero when nothing requests)
//   idx       : winner index
//   any_valid : at least one request present
// ---------------------------------------------------------------------------
module mac_rr_pick
    import mac_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_valid
);
    // cand[k] is the index with priority rank k (0 = highest).
    logic [IW-1:0] cand [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = IW'((int'(ptr) + gi) % N);
        end
    endgenerate

    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        grant     = '0;
        // Walk from lowest to highest priority so the last hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx       = cand[k];
                any_valid = 1'b1;
            end
        end
        if (any_valid) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mac_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mac_rr_arbiter
// Round-robin sharing of one registered a*b + c datapath between NUM_REQ
// requesters; one operation in flight at a time (IDLE -> COMPUTE -> RESP).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mac_rr_arbiter_if.slave (request handshakes, response channel, busy)
// Optional feature macro: MAC_ACCUM_EN adds a per-requester accumulator that
// is added into the result when the requester's req_acc bit is set.
// ---------------------------------------------------------------------------
module mac_rr_arbiter
    import mac_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
    input logic             clk,
    input logic             reset,
    mac_rr_arbiter_if.slave bus
);
    localparam int ID_WIDTH = id_width(NUM_REQ);

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [OUT_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    busy_q, busy_d;
`ifdef MAC_ACCUM_EN
    logic                    acc_en_q, acc_en_d;
    logic [OUT_WIDTH-1:0]    acc_q [NUM_REQ];
    logic [OUT_WIDTH-1:0]    acc_d [NUM_REQ];
`endif

    logic [NUM_REQ-1:0]      grant;
    logic [ID_WIDTH-1:0]     win_idx;
    logic                    any_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [OUT_WIDTH-1:0]    mac_sum;

    // Unpack the flattened operand buses.
    logic [DATA_WIDTH-1:0]   a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   b_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   c_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_arr[gi] = bus.req_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign c_arr[gi] = bus.req_c[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    mac_rr_pick #(.N(NUM_REQ), .IW(ID_WIDTH)) u_pick (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .idx       (win_idx),
        .any_valid (any_valid)
    );

    // Operands are zero-extended to the result width before the multiply so
    // 255*255+255 fits without truncation.
    always_comb begin
        mac_sum = OUT_WIDTH'(a_q) * OUT_WIDTH'(b_q) + OUT_WIDTH'(c_q);
`ifdef MAC_ACCUM_EN
        if (acc_en_q) begin
            mac_sum = mac_sum + acc_q[id_q];
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = '0;
`ifdef MAC_ACCUM_EN
        acc_en_d    = acc_en_q;
        acc_d       = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Gated by reset so req_ready reads 0 while reset is held.
                if (any_valid && reset) begin
                    req_ready = grant;
                    a_d       = a_arr[win_idx];
                    b_d       = b_arr[win_idx];
                    c_d       = c_arr[win_idx];
                    id_d      = win_idx;
`ifdef MAC_ACCUM_EN
                    acc_en_d  = bus.req_acc[win_idx];
`endif
                    state_d   = COMPUTE;
                end
            end
            COMPUTE: begin
                rsp_data_d  = mac_sum;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
`ifdef MAC_ACCUM_EN
                acc_d[id_q] = mac_sum;
`endif
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // Pointer only moves on a completed response.
                    rr_ptr_d    = (id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id_q + ID_WIDTH'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            id_q        <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MAC_ACCUM_EN
            acc_en_q    <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                acc_q[i] <= '0;
            end
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef MAC_ACCUM_EN
            acc_en_q    <= acc_en_d;
            acc_q       <= acc_d;
`endif
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/mac_rr_arbiter.md
Name: mac_rr_arbiter

Overview:
- Shares one registered 8x8+8 multiply-add datapath (result = a*b + c) between NUM_REQ independent requesters.
- Arbitration is round-robin. Requests use a valid/ready handshake; results come back on a single response channel tagged with the requester ID and honour backpressure.
- Sits between the software-visible or VIO-driven operand sources and the shared MAC.
- The FSM serialises operations: one in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, width of a, b and c operands.
- OUT_WIDTH, 16, result width; 2*DATA_WIDTH, holds max 255*255+255 = 65280 without overflow.
- ID_WIDTH (localparam), clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant/accept; bit i high means operands of i are captured this cycle.
- req_a  in  NUM_REQ*DATA_WIDTH  flattened operand a; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  flattened operand b, same packing.
- req_c  in  NUM_REQ*DATA_WIDTH  flattened addend c, same packing.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  OUT_WIDTH  a*b + c, unsigned.
- rsp_id  out  ID_WIDTH  index of requester that owns rsp_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - All operand registers cleared.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other bits stay 0. No req_ready is raised when there are no requests.
  - On that edge, capture a, b, c and ID of the winner, then go to COMPUTE.
- COMPUTE (1 cycle):
  - rsp_data <= a*b + c.
  - Both operands are zero-extended to OUT_WIDTH before the multiply and add.
  - rsp_id <= captured ID; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable until rsp_ready=1.
  - On the handshake: rsp_valid<=0, rr_ptr <= (ID+1) mod NUM_REQ, go to IDLE.
  - rr_ptr advances only on a completed response.
- Latency: accept edge -> rsp_valid high 2 cycles later. Peak throughput is 1 op per 3 cycles when rsp_ready is held at 1.
- req_ready is 0 in COMPUTE and RESP. Requesters must hold valid and operands until they see ready.
- Deasserting req_valid before grant withdraws the request; no error is raised.
- Simultaneous requests: the highest-priority index relative to rr_ptr wins. Every continuously asserting requester is served within NUM_REQ operations.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-operation (COMPUTE or RESP) discards the in-flight result. No response is emitted for it.
- All outputs are registered except req_ready, which is decoded from state and winner.

Optional Feature:
- Macro: MAC_ACCUM_EN.
- When defined:
  - Adds input req_acc [NUM_REQ] and one OUT_WIDTH accumulator register per requester, cleared by reset.
  - If the granted requester's req_acc bit was 1 at capture, the result is a*b + c + acc[ID], wrapping modulo 2^OUT_WIDTH, and acc[ID] is updated to that result in COMPUTE.
  - If the bit was 0, the result is a*b + c and acc[ID] is overwritten with it.
- When undefined: the req_acc port and accumulators are absent; the result is always a*b + c.

Decomposition:
- Package mac_pkg:
  - DATA_WIDTH and OUT_WIDTH default constants.
  - State enum typedef (IDLE, COMPUTE, RESP).
  - Requester-ID width function (clog2).
- Sub-module mac_rr_pick: combinational. Inputs are the req vector and rr_ptr; outputs are a one-hot grant, the winner index and an any_valid flag. It is reusable by other shared-resource arbiters.

Test Plan:
- Single request: req_valid=4'b0001, a=3, b=5, c=7, rsp_ready=1 -> req_ready[0] pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_data=22, rsp_id=0; then rr_ptr=1.
- Max values: a=255, b=255, c=255 on requester 2 -> rsp_data=65280 (0xFF00), rsp_id=2, no overflow.
- Round-robin fairness: all four req_valid held at 1 with distinct operands, rsp_ready=1 -> responses in ID order 0,1,2,3,0; one accept every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; req_ready stays 0. Raising rsp_ready completes the transfer and returns to IDLE next cycle.
- Async reset mid-op: reset=0 asserted between clock edges during COMPUTE -> all outputs 0 immediately; after release, no stale response; the next grant starts from requester 0.
- MAC_ACCUM_EN: requester 1 issues (2,3,1,acc=0), then (4,4,0,acc=1) -> rsp_data 7, then 23. Requester 1 then issues (0,0,0,acc=0) -> 0. Accumulator wrap check: acc=0xFFF0, op (4,4,0,acc=1) -> 0x0000.
